// File: rtl/mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared definitions for the data-SRAM arbiter: the owner FSM encoding and
// the requester IDs carried down the read-response pipeline.
// ---------------------------------------------------------------------------
package mem_arbiter_pkg;

    // Owner of the most recent grant. The encoding is fixed because the
    // owner state is also read by debug and verification tooling.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CPU  = 2'd1,
        ST_EXT  = 2'd2
    } owner_e;

    // Requester identity tagged onto an issued load so that the returning
    // SRAM data is steered to the port that asked for it.
    typedef logic req_id_t;

    localparam req_id_t REQ_ID_CPU = 1'b0;
    localparam req_id_t REQ_ID_EXT = 1'b1;

endpackage : mem_arbiter_pkg

// File: rtl/mem_arbiter_rsp_pipe.sv
// ---------------------------------------------------------------------------
// arb_rsp_pipe
// One-stage read-response pipeline. An issued load is recorded together with
// the requester ID. One cycle later the SRAM read data is steered to that
// requester, and the other requester's rdata is forced to zero.
// Asynchronous reset drops any response that is still in flight.
// ---------------------------------------------------------------------------
module arb_rsp_pipe
    import mem_arbiter_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              arst,
    input  logic              i_issue,       // a load is granted this cycle
    input  req_id_t           i_id,          // which requester owns that load
    input  logic [DATA_W-1:0] i_mem_rdata,   // SRAM data, valid 1 cycle after issue
    output logic              o_cpu_rvalid,
    output logic [DATA_W-1:0] o_cpu_rdata,
    output logic              o_ext_rvalid,
    output logic [DATA_W-1:0] o_ext_rdata
);

    logic    r_valid;
    req_id_t r_id;

    // Capture the issued load each cycle; a new response slot opens every cycle.
    // NOTE: sequential state uses non-blocking assignments so that every flop
    // samples the values from before the edge, whatever the statement order.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_valid <= 1'b0;
            r_id    <= REQ_ID_CPU;
        end else begin
            r_valid <= i_issue;
            r_id    <= i_id;
        end
    end

    // Steer the returning data only to the owner of the response; otherwise drive zero.
    always_comb begin
        o_cpu_rvalid = r_valid && (r_id == REQ_ID_CPU);
        o_ext_rvalid = r_valid && (r_id == REQ_ID_EXT);
        o_cpu_rdata  = o_cpu_rvalid ? i_mem_rdata : '0;
        o_ext_rdata  = o_ext_rvalid ? i_mem_rdata : '0;
    end

endmodule : arb_rsp_pipe

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Shares a single data-SRAM port between the CPU MEM stage and a host loader.
// Grants are combinational from the current requests and the owner FSM.
// A host burst (ext_lock) keeps ownership of the port.
// The conflict policy is chosen at build time:
//   MEM_ARB_RR_EN defined   -> round-robin: the non-owner wins a conflict,
//                              and the CPU wins when the FSM is in IDLE.
//   MEM_ARB_RR_EN undefined -> fixed priority: the CPU always wins.
// ---------------------------------------------------------------------------
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              arst,
    input  logic              enable,
    // CPU MEM-stage port
    input  logic              cpu_req,
    input  logic              cpu_wen,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    // Host loader port
    input  logic              ext_req,
    input  logic              ext_wen,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    input  logic              ext_lock,
    output logic              ext_gnt,
    output logic              ext_rvalid,
    output logic [DATA_W-1:0] ext_rdata,
    // Data SRAM port
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic              mem_ren,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    owner_e  r_state;
    logic    w_lock_active;
    logic    w_cpu_gnt;
    logic    w_ext_gnt;
    logic    w_load_issue;
    req_id_t w_load_id;

    // A burst is live only while the host still owns the port and still requests.
    assign w_lock_active = (r_state == ST_EXT) && ext_lock && ext_req;

    // Pick at most one requester per cycle. Reset and a low enable block all grants.
    // NOTE: both grants get a default before any branch. Without it, the
    // unassigned paths of this combinational block would infer latches.
    always_comb begin
        w_cpu_gnt = 1'b0;
        w_ext_gnt = 1'b0;
        if (!arst && enable) begin
            if (w_lock_active) begin
                w_ext_gnt = 1'b1;
            end else if (cpu_req && ext_req) begin
`ifdef MEM_ARB_RR_EN
                // Alternate: whoever did not own the last grant goes next.
                if (r_state == ST_CPU) begin
                    w_ext_gnt = 1'b1;
                end else begin
                    w_cpu_gnt = 1'b1;
                end
`else
                w_cpu_gnt = 1'b1;
`endif
            end else begin
                w_cpu_gnt = cpu_req;
                w_ext_gnt = ext_req;
            end
        end
    end

    assign cpu_gnt   = w_cpu_gnt;
    assign ext_gnt   = w_ext_gnt;
    assign cpu_stall = cpu_req & ~w_cpu_gnt;

    // Drive the SRAM port from the granted requester; an idle port is all zeros.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wen   = 1'b0;
        mem_ren   = 1'b0;
        if (w_cpu_gnt) begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_wen   = cpu_wen;
            mem_ren   = ~cpu_wen;
        end else if (w_ext_gnt) begin
            mem_addr  = ext_addr;
            mem_wdata = ext_wdata;
            mem_wen   = ext_wen;
            mem_ren   = ~ext_wen;
        end
    end

    // Owner FSM: follows the last grant, keeps EXT through a locked gap, and holds while disabled.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_state <= ST_IDLE;
        end else if (enable) begin
            if (w_cpu_gnt) begin
                r_state <= ST_CPU;
            end else if (w_ext_gnt) begin
                r_state <= ST_EXT;
            end else if (!((r_state == ST_EXT) && ext_lock)) begin
                r_state <= ST_IDLE;
            end
        end
    end

    // Only loads produce a response. A store completes in its grant cycle.
    assign w_load_issue = (w_cpu_gnt & ~cpu_wen) | (w_ext_gnt & ~ext_wen);
    assign w_load_id    = w_ext_gnt ? REQ_ID_EXT : REQ_ID_CPU;

    arb_rsp_pipe #(
        .DATA_W (DATA_W)
    ) u_rsp_pipe (
        .clk          (clk),
        .arst         (arst),
        .i_issue      (w_load_issue),
        .i_id         (w_load_id),
        .i_mem_rdata  (mem_rdata),
        .o_cpu_rvalid (cpu_rvalid),
        .o_cpu_rdata  (cpu_rdata),
        .o_ext_rvalid (ext_rvalid),
        .o_ext_rdata  (ext_rdata)
    );

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
// Directed bench for mem_arbiter. Expectations follow the conflict policy
// selected by MEM_ARB_RR_EN. A small SRAM model returns pat(addr) one cycle
// after each read.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int AW = 64;
    localparam int DW = 64;

    logic          clk;
    logic          arst;
    logic          enable;
    logic          cpu_req, cpu_wen, cpu_gnt, cpu_stall, cpu_rvalid;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic          ext_req, ext_wen, ext_lock, ext_gnt, ext_rvalid;
    logic [AW-1:0] ext_addr;
    logic [DW-1:0] ext_wdata, ext_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_wen, mem_ren;
    logic [DW-1:0] mem_wdata, mem_rdata;

    int n_vec = 0;
    int n_err = 0;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk        (clk),
        .arst       (arst),
        .enable     (enable),
        .cpu_req    (cpu_req),
        .cpu_wen    (cpu_wen),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_stall  (cpu_stall),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .ext_req    (ext_req),
        .ext_wen    (ext_wen),
        .ext_addr   (ext_addr),
        .ext_wdata  (ext_wdata),
        .ext_lock   (ext_lock),
        .ext_gnt    (ext_gnt),
        .ext_rvalid (ext_rvalid),
        .ext_rdata  (ext_rdata),
        .mem_addr   (mem_addr),
        .mem_wen    (mem_wen),
        .mem_ren    (mem_ren),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data pattern stored at each address by the SRAM model.
    function automatic logic [63:0] pat(input logic [63:0] a);
        return {a[31:0] ^ 32'hC0DE_0000, ~a[31:0]};
    endfunction

    // SRAM model: read data appears one cycle after mem_ren.
    always @(posedge clk or posedge arst) begin
        if (arst) mem_rdata <= '0;
        else if (mem_ren) mem_rdata <= pat(mem_addr);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic cr, input logic cw, input logic [63:0] ca, input logic [63:0] cd,
                          input logic er, input logic ew, input logic [63:0] ea, input logic [63:0] ed,
                          input logic lk);
        cpu_req = cr; cpu_wen = cw; cpu_addr = ca; cpu_wdata = cd;
        ext_req = er; ext_wen = ew; ext_addr = ea; ext_wdata = ed;
        ext_lock = lk;
    endtask

    task automatic idle_in;
        set_in(0, 0, 64'h0, 64'h0, 0, 0, 64'h0, 64'h0, 0);
    endtask

    task automatic test_reset;
        set_in(1, 0, 64'h10, 64'h0, 1, 0, 64'h18, 64'h0, 0);
        #3;
        n_vec++;
        if ({cpu_gnt, ext_gnt, mem_ren, mem_wen, cpu_rvalid, ext_rvalid} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_ctl: got %b want 000000", {cpu_gnt, ext_gnt, mem_ren, mem_wen, cpu_rvalid, ext_rvalid});
        end
        n_vec++;
        if (cpu_stall !== 1'b1) begin
            n_err++;
            $display("FAIL reset_stall: got %b want 1", cpu_stall);
        end
        n_vec++;
        if ({mem_addr, mem_wdata, cpu_rdata, ext_rdata} !== 256'h0) begin
            n_err++;
            $display("FAIL reset_data: addr %h wdata %h crd %h erd %h want all 0", mem_addr, mem_wdata, cpu_rdata, ext_rdata);
        end
        tick;
        arst = 1'b0;
        idle_in;
        #3;
        n_vec++;
        if (dut.r_state !== ST_IDLE) begin
            n_err++;
            $display("FAIL reset_state: got %0d want %0d", dut.r_state, ST_IDLE);
        end
    endtask

    task automatic test_cpu_load;
        tick;
        set_in(1, 0, 64'h10, 64'h0, 0, 0, 64'h0, 64'h0, 0);
        #3;
        n_vec++;
        if ({cpu_gnt, ext_gnt, mem_ren, mem_wen, cpu_stall} !== 5'b10100) begin
            n_err++;
            $display("FAIL cpu_load_gnt: got %b want 10100", {cpu_gnt, ext_gnt, mem_ren, mem_wen, cpu_stall});
        end
        n_vec++;
        if (mem_addr !== 64'h10) begin
            n_err++;
            $display("FAIL cpu_load_addr: got %h want 10", mem_addr);
        end
        tick;
        idle_in;
        #3;
        n_vec++;
        if ({cpu_rvalid, ext_rvalid} !== 2'b10) begin
            n_err++;
            $display("FAIL cpu_load_rvalid: got %b want 10", {cpu_rvalid, ext_rvalid});
        end
        n_vec++;
        if (cpu_rdata !== 64'hC0DE0010_FFFFFFEF || ext_rdata !== 64'h0) begin
            n_err++;
            $display("FAIL cpu_load_rdata: got %h/%h want c0de0010ffffffef/0", cpu_rdata, ext_rdata);
        end
        tick;
        #3;
        n_vec++;
        if (cpu_rvalid !== 1'b0) begin
            n_err++;
            $display("FAIL cpu_load_one_shot: got %b want 0", cpu_rvalid);
        end
    endtask

    task automatic test_conflict;
        logic [2:0] exp_cpu;
`ifdef MEM_ARB_RR_EN
        exp_cpu = 3'b101;   // cycle0 = bit0: CPU, EXT, CPU
`else
        exp_cpu = 3'b111;
`endif
        for (int i = 0; i < 3; i++) begin
            tick;
            set_in(1, 0, 64'h20, 64'h0, 1, 0, 64'h30, 64'h0, 0);
            #3;
            n_vec++;
            if ({cpu_gnt, ext_gnt, cpu_stall} !== {exp_cpu[i], ~exp_cpu[i], ~exp_cpu[i]}) begin
                n_err++;
                $display("FAIL conflict_gnt[%0d]: got %b want %b", i, {cpu_gnt, ext_gnt, cpu_stall},
                         {exp_cpu[i], ~exp_cpu[i], ~exp_cpu[i]});
            end
            if (i > 0) begin
                n_vec++;
                if ({cpu_rvalid, ext_rvalid} !== {exp_cpu[i-1], ~exp_cpu[i-1]}) begin
                    n_err++;
                    $display("FAIL conflict_rvalid[%0d]: got %b want %b", i, {cpu_rvalid, ext_rvalid},
                             {exp_cpu[i-1], ~exp_cpu[i-1]});
                end
            end
        end
        tick;
        idle_in;
        #3;
        n_vec++;
        if ({cpu_rvalid, ext_rvalid} !== 2'b10 || cpu_rdata !== pat(64'h20)) begin
            n_err++;
            $display("FAIL conflict_last_rsp: got %b %h want 10 %h", {cpu_rvalid, ext_rvalid}, cpu_rdata, pat(64'h20));
        end
        tick;
    endtask

    task automatic test_lock_burst;
        tick;
        set_in(0, 0, 64'h0, 64'h0, 1, 0, 64'h0, 64'h0, 0);
        #3;
        n_vec++;
        if ({cpu_gnt, ext_gnt} !== 2'b01 || mem_addr !== 64'h0) begin
            n_err++;
            $display("FAIL lock_first: got %b addr %h want 01 addr 0", {cpu_gnt, ext_gnt}, mem_addr);
        end
        for (int i = 1; i <= 4; i++) begin
            tick;
            set_in(1, 0, 64'h40, 64'h0, 1, 0, 64'(i * 8), 64'h0, 1);
            #3;
            n_vec++;
            if ({cpu_gnt, ext_gnt, cpu_stall} !== 3'b011 || mem_addr !== 64'(i * 8)) begin
                n_err++;
                $display("FAIL lock_burst[%0d]: got %b addr %h want 011 addr %h", i, {cpu_gnt, ext_gnt, cpu_stall},
                         mem_addr, 64'(i * 8));
            end
            n_vec++;
            if (ext_rvalid !== 1'b1 || ext_rdata !== pat(64'((i - 1) * 8))) begin
                n_err++;
                $display("FAIL lock_rsp[%0d]: got %b %h want 1 %h", i, ext_rvalid, ext_rdata, pat(64'((i - 1) * 8)));
            end
        end
        tick;
        set_in(1, 0, 64'h40, 64'h0, 0, 0, 64'h0, 64'h0, 0);
        #3;
        n_vec++;
        if ({cpu_gnt, ext_gnt, cpu_stall} !== 3'b100) begin
            n_err++;
            $display("FAIL lock_release: got %b want 100", {cpu_gnt, ext_gnt, cpu_stall});
        end
        tick;
        idle_in;
        #3;
        n_vec++;
        if (cpu_rvalid !== 1'b1 || cpu_rdata !== pat(64'h40)) begin
            n_err++;
            $display("FAIL lock_cpu_rsp: got %b %h want 1 %h", cpu_rvalid, cpu_rdata, pat(64'h40));
        end
        tick;
    endtask

    task automatic test_store;
        tick;
        set_in(0, 0, 64'h0, 64'h0, 1, 1, 64'h8, 64'hDEAD, 0);
        #3;
        n_vec++;
        if ({cpu_gnt, ext_gnt, mem_ren, mem_wen} !== 4'b0101) begin
            n_err++;
            $display("FAIL store_ctl: got %b want 0101", {cpu_gnt, ext_gnt, mem_ren, mem_wen});
        end
        n_vec++;
        if (mem_wdata !== 64'hDEAD || mem_addr !== 64'h8) begin
            n_err++;
            $display("FAIL store_data: got %h @ %h want dead @ 8", mem_wdata, mem_addr);
        end
        tick;
        idle_in;
        #3;
        n_vec++;
        if ({cpu_rvalid, ext_rvalid} !== 2'b00 || ext_rdata !== 64'h0) begin
            n_err++;
            $display("FAIL store_no_rsp: got %b %h want 00 0", {cpu_rvalid, ext_rvalid}, ext_rdata);
        end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 5; i++) begin
            tick;
            if (i < 4) set_in(1, 0, 64'h100 + 64'(i * 8), 64'h0, 0, 0, 64'h0, 64'h0, 0);
            else idle_in;
            #3;
            if (i < 4) begin
                n_vec++;
                if ({cpu_gnt, cpu_stall, mem_ren} !== 3'b101) begin
                    n_err++;
                    $display("FAIL b2b_gnt[%0d]: got %b want 101", i, {cpu_gnt, cpu_stall, mem_ren});
                end
            end
            if (i > 0) begin
                n_vec++;
                if (cpu_rvalid !== 1'b1 || cpu_rdata !== pat(64'h100 + 64'((i - 1) * 8))) begin
                    n_err++;
                    $display("FAIL b2b_rsp[%0d]: got %b %h want 1 %h", i, cpu_rvalid, cpu_rdata,
                             pat(64'h100 + 64'((i - 1) * 8)));
                end
            end
        end
    endtask

    task automatic test_reset_inflight;
        tick;
        set_in(1, 0, 64'h200, 64'h0, 0, 0, 64'h0, 64'h0, 0);
        #3;
        n_vec++;
        if (cpu_gnt !== 1'b1) begin
            n_err++;
            $display("FAIL rst_inflight_gnt: got %b want 1", cpu_gnt);
        end
        tick;
        arst = 1'b1;
        idle_in;
        #3;
        n_vec++;
        if (cpu_rvalid !== 1'b0 || cpu_rdata !== 64'h0 || dut.r_state !== ST_IDLE) begin
            n_err++;
            $display("FAIL rst_inflight_drop: rvalid %b rdata %h state %0d want 0 0 0", cpu_rvalid, cpu_rdata, dut.r_state);
        end
        tick;
        arst = 1'b0;
        #3;
        n_vec++;
        if (cpu_rvalid !== 1'b0) begin
            n_err++;
            $display("FAIL rst_inflight_late: got %b want 0", cpu_rvalid);
        end
        tick;
        set_in(1, 0, 64'h210, 64'h0, 1, 0, 64'h218, 64'h0, 0);
        #3;
        n_vec++;
        if ({cpu_gnt, ext_gnt, cpu_rvalid} !== 3'b100) begin
            n_err++;
            $display("FAIL rst_first_gnt: got %b want 100", {cpu_gnt, ext_gnt, cpu_rvalid});
        end
        tick;
        idle_in;
        tick;
    endtask

    task automatic test_enable;
        logic exp_cpu;
`ifdef MEM_ARB_RR_EN
        exp_cpu = 1'b0;     // owner held at CPU, so the host wins
`else
        exp_cpu = 1'b1;
`endif
        tick;
        set_in(1, 0, 64'h300, 64'h0, 0, 0, 64'h0, 64'h0, 0);
        #3;
        n_vec++;
        if (cpu_gnt !== 1'b1) begin
            n_err++;
            $display("FAIL en_pre_gnt: got %b want 1", cpu_gnt);
        end
        tick;
        enable = 1'b0;
        set_in(1, 0, 64'h308, 64'h0, 1, 0, 64'h310, 64'h0, 0);
        #3;
        n_vec++;
        if ({cpu_gnt, ext_gnt, mem_ren, mem_wen, cpu_stall} !== 5'b00001) begin
            n_err++;
            $display("FAIL en_off_ctl: got %b want 00001", {cpu_gnt, ext_gnt, mem_ren, mem_wen, cpu_stall});
        end
        n_vec++;
        if (cpu_rvalid !== 1'b1 || cpu_rdata !== pat(64'h300)) begin
            n_err++;
            $display("FAIL en_off_pending: got %b %h want 1 %h", cpu_rvalid, cpu_rdata, pat(64'h300));
        end
        tick;
        #3;
        n_vec++;
        if ({cpu_gnt, ext_gnt, cpu_rvalid, cpu_stall} !== 4'b0001) begin
            n_err++;
            $display("FAIL en_off_hold: got %b want 0001", {cpu_gnt, ext_gnt, cpu_rvalid, cpu_stall});
        end
        tick;
        enable = 1'b1;
        #3;
        n_vec++;
        if ({cpu_gnt, ext_gnt} !== {exp_cpu, ~exp_cpu}) begin
            n_err++;
            $display("FAIL en_resume: got %b want %b", {cpu_gnt, ext_gnt}, {exp_cpu, ~exp_cpu});
        end
        tick;
        idle_in;
        tick;
    endtask

    initial begin
        arst   = 1'b1;
        enable = 1'b1;
        idle_in;
        #2;
        test_reset;
        test_cpu_load;
        test_conflict;
        test_lock_burst;
        test_store;
        test_back_to_back;
        test_reset_inflight;
        test_enable;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_mem_arbiter
